// File: rtl/msp430_pkg.sv
// Shared MSP430 register-file definitions: register indices, SR flag bit
// positions, source addressing modes and the write request format.
package msp430_pkg;

  localparam int DW    = 16;
  localparam int IDX_W = 4;

  localparam logic [IDX_W-1:0] PC = 4'd0;
  localparam logic [IDX_W-1:0] SP = 4'd1;
  localparam logic [IDX_W-1:0] SR = 4'd2;
  localparam logic [IDX_W-1:0] CG = 4'd3;

  localparam int SR_C = 0;
  localparam int SR_Z = 1;
  localparam int SR_N = 2;
  localparam int SR_V = 8;

  typedef enum logic [1:0] {
    AS_REG = 2'b00,
    AS_IDX = 2'b01,
    AS_IND = 2'b10,
    AS_INC = 2'b11
  } as_mode_e;

  typedef struct packed {
    logic             en;
    logic             byte_w;
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    data;
  } wr_req_t;

  // PC and SP are word aligned, so bit 0 never holds a 1.
  function automatic logic [DW-1:0] fmt_wr(wr_req_t r);
    logic [DW-1:0] d;
    d = r.byte_w ? {8'h00, r.data[7:0]} : r.data;
    if (r.idx == PC || r.idx == SP) d[0] = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/reg_cg.sv
// R2/R3 constant generator: decodes SA/As into an immediate source operand.
// Only built when REGFILE_CG_EN is defined.
`ifdef REGFILE_CG_EN
module reg_cg
  import msp430_pkg::*;
(
  input  logic [IDX_W-1:0] sa,
  input  as_mode_e         as_mode,
  input  logic [DW-1:0]    r2,
  output logic             cg_vld,
  output logic [DW-1:0]    cg_val
);

  always_comb begin
    cg_vld = 1'b0;
    cg_val = '0;
    case (sa)
      CG: begin
        cg_vld = 1'b1;
        case (as_mode)
          AS_REG:  cg_val = 16'h0000;
          AS_IDX:  cg_val = 16'h0001;
          AS_IND:  cg_val = 16'h0002;
          default: cg_val = 16'hFFFF;
        endcase
      end
      SR: begin
        // As=00 is plain register mode, so R2 passes through untouched.
        cg_vld = 1'b1;
        case (as_mode)
          AS_REG:  cg_val = r2;
          AS_IDX:  cg_val = 16'h0000;
          AS_IND:  cg_val = 16'h0004;
          default: cg_val = 16'h0008;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`endif

// File: rtl/reg_file.sv
// MSP430 R0-R15 register file with PC increment, SR flag load and async reads.
// REGFILE_CG_EN enables the R2/R3 constant generator and makes R3 read-only zero.
module reg_file
  import msp430_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int PC_STEP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RW,
  input  logic             BW,
  input  logic [IDX_W-1:0] DA,
  input  logic [IDX_W-1:0] SA,
  input  logic [1:0]       As,
  input  logic [DW-1:0]    reg_Din,
  input  logic             PC_inc,
  input  logic             SR_we,
  input  logic [3:0]       flags_in,
  output logic [DW-1:0]    Sout,
  output logic [DW-1:0]    Dout,
  output logic [DW-1:0]    PC_out,
  output logic [DW-1:0]    SR_out,
  output logic             wr_ack
);

  localparam logic [DW-1:0] PC_STEP_W = DW'(PC_STEP);

  logic [NREGS-1:0][DW-1:0] rf;
  wr_req_t                  wr;
  logic [DW-1:0]            wr_data;
  logic                     wr_keep;
  logic                     wr_do;

  always_comb begin
    wr      = '{en: RW, byte_w: BW, idx: DA, data: reg_Din};
    wr_data = fmt_wr(wr);
  end

`ifdef REGFILE_CG_EN
  assign wr_keep = (DA != CG);
`else
  assign wr_keep = 1'b1;
`endif
  assign wr_do = wr.en && wr_keep;

  // The explicit write is issued last so it overrides PC_inc / SR_we
  // when it targets the same register in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf     <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= RW;
      if (PC_inc) rf[PC] <= rf[PC] + PC_STEP_W;
      if (SR_we) begin
        rf[SR][SR_V] <= flags_in[3];
        rf[SR][SR_N] <= flags_in[2];
        rf[SR][SR_Z] <= flags_in[1];
        rf[SR][SR_C] <= flags_in[0];
      end
      if (wr_do) rf[wr.idx] <= wr_data;
    end
  end

  assign PC_out = rf[PC];
  assign SR_out = rf[SR];

`ifdef REGFILE_CG_EN
  logic          cg_vld;
  logic [DW-1:0] cg_val;

  reg_cg u_cg (
    .sa      (SA),
    .as_mode (as_mode_e'(As)),
    .r2      (rf[SR]),
    .cg_vld  (cg_vld),
    .cg_val  (cg_val)
  );

  always_comb begin
    Sout = cg_vld ? cg_val : rf[SA];
    Dout = (DA == CG) ? '0 : rf[DA];
  end
`else
  logic [1:0] unused_as;
  assign unused_as = As;

  always_comb begin
    Sout = rf[SA];
    Dout = rf[DA];
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected outputs into a
// scoreboard, a negedge monitor pops and compares them.
module tb_reg_file;

`ifdef REGFILE_CG_EN
  localparam bit CG_ON = 1'b1;
`else
  localparam bit CG_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, RW, BW, PC_inc, SR_we;
  logic [3:0]  DA, SA, flags_in;
  logic [1:0]  As;
  logic [15:0] reg_Din;
  logic [15:0] Sout, Dout, PC_out, SR_out;
  logic        wr_ack;

  always #5 clk = ~clk;

  reg_file #(.NREGS(16), .PC_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .RW(RW), .BW(BW), .DA(DA), .SA(SA), .As(As),
    .reg_Din(reg_Din), .PC_inc(PC_inc), .SR_we(SR_we), .flags_in(flags_in),
    .Sout(Sout), .Dout(Dout), .PC_out(PC_out), .SR_out(SR_out), .wr_ack(wr_ack)
  );

  typedef struct {
    int          cyc;
    int          kind;  // 0 Sout, 1 Dout, 2 PC_out, 3 SR_out, 4 wr_ack
    string       name;
    logic [15:0] exp;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic prev_rw, prev_rst;
  bit   have_prev = 0;

  task automatic chk(input int kind, input string name, input logic [15:0] exp);
    chk_t c;
    c.cyc = cyc; c.kind = kind; c.name = name; c.exp = exp;
    sb.push_back(c);
  endtask

  // Advance one cycle; inputs fall back to idle and the expected wr_ack
  // for the edge just taken is queued.
  task automatic tick();
    prev_rw  = RW;
    prev_rst = rst_n;
    @(posedge clk);
    #1;
    cyc++;
    RW = 0; BW = 0; PC_inc = 0; SR_we = 0; rst_n = 1; flags_in = 0; reg_Din = 0;
    if (have_prev) chk(4, "wr_ack", {15'd0, prev_rw & prev_rst});
    have_prev = 1;
  endtask

  chk_t        mc;
  logic [15:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mc = sb.pop_front();
      case (mc.kind)
        0:       act = Sout;
        1:       act = Dout;
        2:       act = PC_out;
        3:       act = SR_out;
        default: act = {15'd0, wr_ack};
      endcase
      total++;
      if (act !== mc.exp) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", mc.name, mc.cyc, act, mc.exp);
      end
    end
  end

  logic [3:0]  cg_sa  [8] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2};
  logic [1:0]  cg_as  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [15:0] cg_exp [8] = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF,
                              16'h00F0, 16'h0000, 16'h0004, 16'h0008};

  initial begin
    rst_n = 0; RW = 0; BW = 0; PC_inc = 0; SR_we = 0;
    DA = 0; SA = 0; As = 0; flags_in = 0; reg_Din = 0;

    tick(); rst_n = 0;
    tick(); DA = 5;
    chk(1, "reset_dout", 16'h0000); chk(2, "reset_pc", 16'h0000); chk(3, "reset_sr", 16'h0000);

    tick(); RW = 1; DA = 5; reg_Din = 16'hA5C3;
    tick(); SA = 5;
    chk(1, "word_wr_dout", 16'hA5C3); chk(0, "word_wr_sout", 16'hA5C3);

    tick(); RW = 1; BW = 1; DA = 6; reg_Din = 16'h12FE;
    tick(); DA = 6;
    chk(1, "byte_wr", 16'h00FE);
    tick(); RW = 1; DA = 3; reg_Din = 16'hBEEF;
    tick(); DA = 3; SA = 3; As = 0;
    chk(1, "r3_dout", CG_ON ? 16'h0000 : 16'hBEEF);
    chk(0, "r3_sout", CG_ON ? 16'h0000 : 16'hBEEF);

    tick(); RW = 1; DA = 0; reg_Din = 16'hFFFE;
    tick(); PC_inc = 1;
    chk(2, "pc_load", 16'hFFFE);
    tick(); PC_inc = 1; RW = 1; DA = 0; reg_Din = 16'h4401;
    chk(2, "pc_wrap", 16'h0000);
    tick();
    chk(2, "pc_wr_wins", 16'h4400);

    tick(); SR_we = 1; flags_in = 4'b1011;
    chk(3, "sr_pre", 16'h0000);
    tick(); SR_we = 1; flags_in = 4'b0100; RW = 1; DA = 2; reg_Din = 16'h00F0;
    chk(3, "sr_flags", 16'h0103);
    tick();
    chk(3, "sr_wr_wins", 16'h00F0);

    tick(); RW = 1; DA = 1; reg_Din = 16'h1235;
    tick(); SA = 1; As = 0;
    chk(0, "sp_bit0", 16'h1234);

    for (int i = 0; i < 8; i++) begin
      tick(); SA = cg_sa[i]; As = cg_as[i];
      chk(0, "cg_sout", CG_ON ? cg_exp[i] : (cg_sa[i] == 4'd3 ? 16'hBEEF : 16'h00F0));
    end

    tick(); PC_inc = 1;
    tick(); SR_we = 1; flags_in = 4'b1011;
    chk(2, "pc_inc", 16'h4402);
    tick(); SR_we = 1; flags_in = 4'b0100;
    chk(3, "sr_keep_bits", 16'h01F3);
    tick();
    chk(3, "sr_clear_flags", 16'h00F4);

    tick(); rst_n = 0; RW = 1; DA = 5; reg_Din = 16'h1111;
    PC_inc = 1; SR_we = 1; flags_in = 4'hF;
    tick(); DA = 5; SA = 6; As = 0;
    chk(1, "rst_r5", 16'h0000); chk(0, "rst_r6", 16'h0000);
    chk(2, "rst_pc", 16'h0000); chk(3, "rst_sr", 16'h0000);
    tick(); DA = 1; SA = 0;
    chk(1, "rst_r1", 16'h0000); chk(0, "rst_r0", 16'h0000);
    tick();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
